// File: rtl/gshare_spec_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gshare_spec_predictor_pkg: rv32i types and saturating-counter helpers      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package gshare_spec_predictor_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [6:0]  rv32i_opcode;

  localparam rv32i_opcode op_lui   = 7'b0110111;
  localparam rv32i_opcode op_auipc = 7'b0010111;
  localparam rv32i_opcode op_jal   = 7'b1101111;
  localparam rv32i_opcode op_jalr  = 7'b1100111;
  localparam rv32i_opcode op_br    = 7'b1100011;
  localparam rv32i_opcode op_load  = 7'b0000011;
  localparam rv32i_opcode op_store = 7'b0100011;
  localparam rv32i_opcode op_imm   = 7'b0010011;
  localparam rv32i_opcode op_reg   = 7'b0110011;

  // Counters are carried at the widest legal width; callers truncate to CTR_BITS.
  localparam int unsigned BP_CTR_MAX_BITS = 4;
  typedef logic [BP_CTR_MAX_BITS-1:0] bp_ctr_t;

  function automatic bp_ctr_t bp_ctr_max(input int unsigned bits);
    return bp_ctr_t'((32'd1 << bits) - 32'd1);
  endfunction

  // Weakly not-taken: 2**(bits-1)-1, which is 0 for a 1-bit counter.
  function automatic bp_ctr_t bp_ctr_reset(input int unsigned bits);
    return (bits <= 1) ? bp_ctr_t'(0) : bp_ctr_t'((32'd1 << (bits - 1)) - 32'd1);
  endfunction

  function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken,
                                       input int unsigned bits);
    if (taken) return (ctr == bp_ctr_max(bits)) ? ctr : ctr + 4'd1;
    else       return (ctr == '0) ? ctr : ctr - 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_spec_predictor_sat_counter_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter_table: register-based pattern-history table of sat. counters   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter_table
  import gshare_spec_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic                wr_valid_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic                wr_taken_i
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] BP_CTR_RESET = CTR_BITS'(bp_ctr_reset(CTR_BITS));

  logic [CTR_BITS-1:0] pht_q [DEPTH];
  logic [CTR_BITS-1:0] wr_ctr_d;

  // Read returns the pre-update value; a same-cycle write is not bypassed.
  assign rd_taken_o = pht_q[rd_idx_i][CTR_BITS-1];

  always_comb begin
    wr_ctr_d = CTR_BITS'(ctr_next(bp_ctr_t'(pht_q[wr_idx_i]), wr_taken_i, CTR_BITS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i] <= BP_CTR_RESET;
      end
    end else if (wr_valid_i) begin
      pht_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gshare_spec_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gshare_spec_predictor: gshare direction predictor, speculative history     |
// | with checkpoint recovery. Optional BP_PERF_EN adds perf counters.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gshare_spec_predictor
  import gshare_spec_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned HIST_BITS = 6,
  parameter int unsigned CTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          pc,
  input  logic [6:0]           op,
  input  logic [31:0]          imm,
  output logic                 pred,
  output logic [31:0]          pred_addr,
  output logic [IDX_BITS-1:0]  pred_idx,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic                 upd_taken,
  input  logic                 upd_mispred,
  input  logic [IDX_BITS-1:0]  upd_idx,
  input  logic [HIST_BITS-1:0] upd_hist
`ifdef BP_PERF_EN
  ,
  output logic [31:0]          perf_branches,
  output logic [31:0]          perf_mispreds
`endif
);

  logic [HIST_BITS-1:0] spec_hist_q, spec_hist_d;
  logic [HIST_BITS-1:0] w_hist_shift, w_hist_recover;
  logic                 w_is_br, w_tbl_taken;

  assign w_is_br   = id_valid && (op == op_br);
  assign pred_idx  = pc[IDX_BITS+1:2] ^ IDX_BITS'(spec_hist_q);
  assign pred      = w_is_br && w_tbl_taken;
  assign pred_addr = pc + imm;
  assign pred_hist = spec_hist_q;

  sat_counter_table #(
    .IDX_BITS (IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pred_idx),
    .rd_taken_o (w_tbl_taken),
    .wr_valid_i (upd_valid),
    .wr_idx_i   (upd_idx),
    .wr_taken_i (upd_taken)
  );

  // The oldest checkpoint bit falls off the end of the shift.
  generate
    if (HIST_BITS == 1) begin : g_hist_one
      logic w_unused_upd_hist;
      assign w_unused_upd_hist = upd_hist[0];
      assign w_hist_shift      = pred;
      assign w_hist_recover    = upd_taken;
    end else begin : g_hist_multi
      logic w_unused_upd_hist;
      assign w_unused_upd_hist = upd_hist[HIST_BITS-1];
      assign w_hist_shift      = {spec_hist_q[HIST_BITS-2:0], pred};
      assign w_hist_recover    = {upd_hist[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // A mispredict flushes the ID instruction, so recovery beats the shift.
  always_comb begin
    spec_hist_d = spec_hist_q;
    if (upd_valid && upd_mispred) begin
      spec_hist_d = w_hist_recover;
    end else if (w_is_br) begin
      spec_hist_d = w_hist_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) spec_hist_q <= '0;
    else     spec_hist_q <= spec_hist_d;
  end

`ifdef BP_PERF_EN
  logic [31:0] perf_branches_q, perf_mispreds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q <= '0;
      perf_mispreds_q <= '0;
    end else if (upd_valid) begin
      perf_branches_q <= perf_branches_q + 32'd1;
      if (upd_mispred) perf_mispreds_q <= perf_mispreds_q + 32'd1;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_mispreds = perf_mispreds_q;
`endif

endmodule
`default_nettype wire
